// File: rtl/proj_sel_pkg.sv
// Shared types and helpers for the design select sequencer.
package proj_sel_pkg;

    localparam int unsigned NUM_PROJECTS_DEF = 13;

    typedef enum logic [1:0] {
        ACTIVE,
        ISOLATE,
        HOLD,
        RELEASE
    } sel_state_t;

    // Id 0 means "none selected", so ids span 0..num_projects.
    function automatic int unsigned id_width(input int unsigned num_projects);
        return $clog2(num_projects + 1);
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the HOLD and RELEASE phases.
module seq_timer #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] count_q, count_d;

    // Load on phase entry, otherwise count down and park at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The phase ends on the cycle the count shows 1.
    assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/design_select_sequencer.sv
// Owns the active project selection and sequences every change safely:
// isolate IO, hold all resets, release the new project, settle, enable IO.
module design_select_sequencer
    import proj_sel_pkg::*;
#(
    parameter int unsigned NUM_PROJECTS  = NUM_PROJECTS_DEF,
    parameter int unsigned HOLD_CYCLES   = 4,
    parameter int unsigned SETTLE_CYCLES = 3,
    localparam int unsigned ID_W         = id_width(NUM_PROJECTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ID_W-1:0]       wr_id,
    output logic [NUM_PROJECTS:1] designs_cs,
    output logic [ID_W-1:0]       active_id,
    output logic                  io_en,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned MAX_CYC = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES
                                                                    : SETTLE_CYCLES;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    sel_state_t            state_q, state_d;
    logic [ID_W-1:0]       active_id_q, active_id_d;
    logic [ID_W-1:0]       req_id_q, req_id_d;
    logic [ID_W-1:0]       pend_id_q, pend_id_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [NUM_PROJECTS:1] cs_q, cs_d;
    logic                  io_en_q, io_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  wr_ok;
    logic                  tmr_load;
    logic [TW-1:0]         tmr_load_val;
    logic                  tmr_expire;

    // All ones except the selected project's bit; id 0 keeps everything held.
    function automatic logic [NUM_PROJECTS:1] cs_decode(input logic [ID_W-1:0] id);
        logic [NUM_PROJECTS:1] cs;
        for (int unsigned i = 1; i <= NUM_PROJECTS; i++) begin
            cs[i] = (id != ID_W'(i));
        end
        return cs;
    endfunction

    assign wr_ok = wr_en && (wr_id <= ID_W'(NUM_PROJECTS));

    seq_timer #(
        .W(TW)
    ) u_seq_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_load_val),
        .expire_o  (tmr_expire)
    );

    // Next-state and registered-output values for the selection sequence.
    always_comb begin
        state_d      = state_q;
        active_id_d  = active_id_q;
        req_id_d     = req_id_q;
        pend_id_d    = pend_id_q;
        pend_vld_d   = pend_vld_q;
        cs_d         = cs_q;
        io_en_d      = io_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = wr_en && !wr_ok;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        // Requests arriving mid-sequence are parked; last one wins.
        if (wr_ok && (state_q != ACTIVE)) begin
            pend_vld_d = 1'b1;
            pend_id_d  = wr_id;
        end

        unique case (state_q)
            ACTIVE: begin
                if (wr_ok || pend_vld_q) begin
                    state_d    = ISOLATE;
                    req_id_d   = wr_ok ? wr_id : pend_id_q;
                    pend_vld_d = 1'b0;
                    io_en_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ISOLATE: begin
                state_d      = HOLD;
                cs_d         = '1;
                tmr_load     = 1'b1;
                tmr_load_val = TW'(HOLD_CYCLES);
            end
            HOLD: begin
                if (tmr_expire) begin
                    state_d      = RELEASE;
                    active_id_d  = req_id_q;
                    cs_d         = cs_decode(req_id_q);
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(SETTLE_CYCLES);
                end
            end
            RELEASE: begin
                if (tmr_expire) begin
                    state_d = ACTIVE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    // A queued request restarts next cycle, so keep IO isolated.
                    io_en_d = (active_id_q != '0) && !pend_vld_d;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    // State and output registers; reset holds every project and isolates IO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACTIVE;
            active_id_q <= '0;
            req_id_q    <= '0;
            pend_id_q   <= '0;
            pend_vld_q  <= 1'b0;
            cs_q        <= '1;
            io_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_id_q <= active_id_d;
            req_id_q    <= req_id_d;
            pend_id_q   <= pend_id_d;
            pend_vld_q  <= pend_vld_d;
            cs_q        <= cs_d;
            io_en_q     <= io_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign designs_cs = cs_q;
    assign active_id  = active_id_q;
    assign io_en      = io_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/design_select_sequencer.md
Name: design_select_sequencer

Overview:
Upstream neighbour of the per-project reset router. Owns the "which student project is active" selection and produces the per-project chip-select/reset-hold vector (designs_cs, bit high = project held in reset) plus the IO-mux select. Any selection change runs a safe sequence: isolate IO, hold resets, release the new project, settle, then enable IO.

Parameters:
NUM_PROJECTS, 13, number of project slots; ids 1..NUM_PROJECTS, id 0 = none selected
HOLD_CYCLES, 4, cycles all designs_cs bits are held high; must be >= 2, covering the 2-flop reset synchroniser downstream
SETTLE_CYCLES, 3, cycles after the new project's cs is released before IO is enabled; must be >= 2
ID_W, $clog2(NUM_PROJECTS+1), id width (derived, not overridden)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
wr_en  input  1  one-cycle request to select wr_id
wr_id  input  ID_W  requested project id
designs_cs  output  NUM_PROJECTS (indexed NUM_PROJECTS:1)  1 = project held in reset; feeds the reset router
active_id  output  ID_W  currently selected id; drives the IO mux
io_en  output  1  1 = IO mux may pass active project's signals
busy  output  1  sequence in progress
done  output  1  one-cycle pulse when a sequence completes
err  output  1  one-cycle pulse when a request is rejected

Behaviour:
- All outputs are registered.
- Reset values: designs_cs all 1s, active_id 0, io_en 0, busy 0, done 0, err 0, state ACTIVE, pending empty.
- Asynchronous rst at any point, including mid-sequence, forces the reset values immediately. The pending request is discarded.
- FSM states: ACTIVE, ISOLATE, HOLD, RELEASE.
- ACTIVE: idle/steady state. io_en = (active_id != 0). designs_cs = all 1s except bit active_id = 0.
- Accepted request in ACTIVE at edge T:
  - T+1: ISOLATE. io_en = 0, busy = 1. designs_cs is unchanged.
  - ISOLATE lasts 1 cycle, then HOLD.
  - HOLD: designs_cs all 1s for exactly HOLD_CYCLES cycles. On exit, active_id is loaded with the requested id.
  - RELEASE: designs_cs bit active_id = 0, all others 1 (all 1s if id 0). Lasts SETTLE_CYCLES cycles, io_en stays 0.
  - Return to ACTIVE: io_en = (active_id != 0), busy = 0, done = 1 for that single cycle.
  - busy is high for exactly 1 + HOLD_CYCLES + SETTLE_CYCLES cycles.
- Writing the same id as active_id is valid and performs a full re-reset of that project (soft reset).
- wr_id = 0 is valid: the sequence runs, ending with all cs high, active_id 0, io_en 0, done pulsed.
- wr_id > NUM_PROJECTS: rejected. err pulses the next cycle; no state, pending or output change.
- Valid write while busy: stored in a one-deep pending register, last write wins. On reaching ACTIVE the pending request starts immediately: done pulses and ISOLATE begins the following cycle, so io_en does not rise in between.
- Invalid write while busy: err pulses; pending is untouched.
- A single hold/settle down-counter is used. Its width is $clog2(max(HOLD_CYCLES, SETTLE_CYCLES)+1). It is loaded on state entry and the state exits when the count reaches 1.

Decomposition:
- Shared package proj_sel_pkg holds:
  - state enum sel_state_t {ACTIVE, ISOLATE, HOLD, RELEASE}
  - NUM_PROJECTS default
  - ID_W helper function
- Sub-module seq_timer: loadable down-counter with load value and expire flag. Keeps the FSM file small.
- Everything else (FSM, pending register, cs decode) stays in design_select_sequencer.

Test Plan:
All scenarios use NUM_PROJECTS=13, HOLD_CYCLES=4, SETTLE_CYCLES=3.
1. Reset release, no writes -> designs_cs=13'h1FFF, active_id=0, io_en=0, busy=0 indefinitely.
2. wr_id=5 at T -> io_en=0 from T+1; cs=1FFF for T+2..T+5; cs=1FEF with active_id=5 from T+6; busy high exactly 8 cycles; done pulse and io_en=1 at T+9.
3. wr_id=14 while ACTIVE with id 5 -> err single pulse at T+1; cs, active_id and io_en unchanged; busy stays 0.
4. During a sequence to 5, write 3 then 7 -> after 5's done, 7's sequence starts with no io_en rise; final active_id=7, cs=1FBF; 3 is never applied.
5. wr_id=5 while active_id=5 -> full 8-cycle re-reset; bit 5 high during HOLD; returns to cs=1FEF, done pulse.
6. Assert rst in HOLD of a 5->9 change -> cs=1FFF, active_id=0, busy=0 immediately; pending cleared; after release a wr_id=9 completes normally.
